axis_input_scheduler: RTL and testbench

// - Sequences the conv input stage for one layer per command: a CONFIG phase (weights only), then a DATA phase (pixel/weight join).
// - DATA loop order: block (outer) x col x cin (inner).
// - Owns the pixel/weight ready signals and generates all position flags (top/bottom block, cols_1_k2, cin_last, config, tlast).
// - Sits between the image/weight pipes and the conv engine input.

---
 rtl/axis_input_scheduler_pkg.sv | 24 ++
 rtl/axis_input_scheduler_counter.sv | 25 ++
 rtl/axis_input_scheduler.sv | 166 ++++++++++++++++
 tb/tb_axis_input_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_input_scheduler_pkg.sv
// Shared constants, field widths and state encoding for the conv input scheduler.
package axis_input_scheduler_pkg;

  localparam int unsigned BEATS_CONFIG_3X3_1 = 20;
  localparam int unsigned BEATS_CONFIG_1X1_1 = 8;
  localparam int unsigned KERNEL_W_MAX       = 3;
  localparam int unsigned IM_CIN_MAX         = 1024;
  localparam int unsigned IM_COLS_MAX        = 384;
  localparam int unsigned IM_BLOCKS_MAX      = 32;

  localparam int unsigned BK   = $clog2(KERNEL_W_MAX);
  localparam int unsigned BC   = $clog2(IM_CIN_MAX);
  localparam int unsigned BL   = $clog2(IM_COLS_MAX);
  localparam int unsigned BB   = $clog2(IM_BLOCKS_MAX);
  localparam int unsigned BCFG = $clog2(BEATS_CONFIG_3X3_1 + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StConfig = 2'd1,
    StData   = 2'd2,
    StDone   = 2'd3
  } state_e;

endpackage

// File: rtl/axis_input_scheduler_counter.sv
// Wrapping up-counter: clears on i_clr, advances on i_en, returns to 0 after reaching i_max.
module sched_wrap_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [Width-1:0] i_max,
  output logic [Width-1:0] o_cnt
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == i_max) ? '0 : r_cnt + Width'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/axis_input_scheduler.sv
// Per-layer input sequencer: CONFIG (weights only) then DATA (pixel/weight join) in
// block x col x cin order, with position flags for the conv engine.
module axis_input_scheduler
  import axis_input_scheduler_pkg::*;
(
  input  logic          aclk,
  input  logic          areset,
  output logic          s_cmd_tready,
  input  logic          s_cmd_tvalid,
  input  logic          s_cmd_is_1x1,
  input  logic [BK-1:0] s_cmd_kw_1,
  input  logic [BC-1:0] s_cmd_cin_1,
  input  logic [BL-1:0] s_cmd_cols_1,
  input  logic [BB-1:0] s_cmd_blocks_1,
  input  logic          pixels_valid,
  output logic          pixels_ready,
  input  logic          weights_valid,
  output logic          weights_ready,
  input  logic          m_tready,
  output logic          m_tvalid,
  output logic          m_tlast,
  output logic          m_is_config,
  output logic          m_is_top_block,
  output logic          m_is_bottom_block,
  output logic          m_is_cols_1_k2,
  output logic          m_is_cin_last,
  output logic          busy,
  output logic          done
);

  state_e r_state, w_state_d;

  logic            r_is_1x1;
  logic [BK-1:0]   r_kw_1;
  logic [BC-1:0]   r_cin_1;
  logic [BL-1:0]   r_cols_1;
  logic [BB-1:0]   r_blocks_1;

  logic [BCFG-1:0] w_cfg_cnt, w_cfg_max;
  logic [BC-1:0]   w_cin_cnt;
  logic [BL-1:0]   w_col_cnt, w_half, w_k2_thr;
  logic [BB-1:0]   w_blk_cnt;
  logic            w_cmd_fire, w_fire, w_cfg_en, w_cin_en, w_col_en, w_blk_en;
  logic            w_cfg_wrap, w_cin_wrap, w_col_wrap, w_blk_wrap, w_last, w_flag_en;

  assign w_cmd_fire = s_cmd_tready && s_cmd_tvalid;
  assign w_fire     = m_tvalid && m_tready;
  assign w_cfg_max  = r_is_1x1 ? BCFG'(BEATS_CONFIG_1X1_1) : BCFG'(BEATS_CONFIG_3X3_1);

  assign w_cfg_wrap = (w_cfg_cnt == w_cfg_max);
  assign w_cin_wrap = (w_cin_cnt == r_cin_1);
  assign w_col_wrap = (w_col_cnt == r_cols_1);
  assign w_blk_wrap = (w_blk_cnt == r_blocks_1);
  assign w_last     = w_cin_wrap && w_col_wrap && w_blk_wrap;

  assign w_cfg_en = w_fire && (r_state == StConfig);
  assign w_cin_en = w_fire && (r_state == StData);
  assign w_col_en = w_cin_en && w_cin_wrap;
  assign w_blk_en = w_col_en && w_col_wrap;

  sched_wrap_counter #(.Width(BCFG)) u_cfg_cnt (
    .i_clk (aclk),
    .i_rst (areset),
    .i_clr (w_cmd_fire),
    .i_en  (w_cfg_en),
    .i_max (w_cfg_max),
    .o_cnt (w_cfg_cnt)
  );

  sched_wrap_counter #(.Width(BC)) u_cin_cnt (
    .i_clk (aclk),
    .i_rst (areset),
    .i_clr (w_cmd_fire),
    .i_en  (w_cin_en),
    .i_max (r_cin_1),
    .o_cnt (w_cin_cnt)
  );

  sched_wrap_counter #(.Width(BL)) u_col_cnt (
    .i_clk (aclk),
    .i_rst (areset),
    .i_clr (w_cmd_fire),
    .i_en  (w_col_en),
    .i_max (r_cols_1),
    .o_cnt (w_col_cnt)
  );

  sched_wrap_counter #(.Width(BB)) u_blk_cnt (
    .i_clk (aclk),
    .i_rst (areset),
    .i_clr (w_cmd_fire),
    .i_en  (w_blk_en),
    .i_max (r_blocks_1),
    .o_cnt (w_blk_cnt)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state    <= StIdle;
      r_is_1x1   <= 1'b0;
      r_kw_1     <= '0;
      r_cin_1    <= '0;
      r_cols_1   <= '0;
      r_blocks_1 <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_cmd_fire) begin
        r_is_1x1   <= s_cmd_is_1x1;
        r_kw_1     <= s_cmd_kw_1;
        r_cin_1    <= s_cmd_cin_1;
        r_cols_1   <= s_cmd_cols_1;
        r_blocks_1 <= s_cmd_blocks_1;
      end
    end
  end

  // Outputs are forced low while reset is held so nothing is popped from the pipes.
  always_comb begin
    w_state_d     = r_state;
    s_cmd_tready  = 1'b0;
    m_tvalid      = 1'b0;
    pixels_ready  = 1'b0;
    weights_ready = 1'b0;
    m_is_config   = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    if (!areset) begin
      busy = (r_state != StIdle);
      unique case (r_state)
        StIdle: begin
          s_cmd_tready = 1'b1;
          if (s_cmd_tvalid) w_state_d = StConfig;
        end
        StConfig: begin
          m_tvalid      = weights_valid;
          weights_ready = m_tready;
          m_is_config   = 1'b1;
          if (weights_valid && m_tready && w_cfg_wrap) w_state_d = StData;
        end
        StData: begin
          m_tvalid      = pixels_valid && weights_valid;
          pixels_ready  = m_tready && weights_valid;
          weights_ready = m_tready && pixels_valid;
          if (pixels_valid && weights_valid && m_tready && w_last) w_state_d = StDone;
        end
        StDone: begin
          done      = 1'b1;
          w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Trailing-column window: cols_1 - kw_1/2, clamped at zero for narrow images.
  assign w_half   = BL'(r_kw_1 >> 1);
  assign w_k2_thr = (r_cols_1 >= w_half) ? (r_cols_1 - w_half) : '0;

  assign w_flag_en         = m_tvalid && (r_state == StData);
  assign m_is_cin_last     = w_flag_en && w_cin_wrap;
  assign m_is_top_block    = w_flag_en && (w_blk_cnt == '0);
  assign m_is_bottom_block = w_flag_en && w_blk_wrap;
  assign m_is_cols_1_k2    = w_flag_en && (w_col_cnt >= w_k2_thr);
  assign m_tlast           = w_flag_en && w_last;

endmodule

// File: tb/tb_axis_input_scheduler.sv
// Self-checking bench: table of layer commands, randomized handshakes against a
// beat-list reference model, plus reset-abort and held-command sequences.
module tb_axis_input_scheduler;
  import axis_input_scheduler_pkg::*;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_cmd_tready, s_cmd_tvalid, s_cmd_is_1x1;
  logic [BK-1:0] s_cmd_kw_1;
  logic [BC-1:0] s_cmd_cin_1;
  logic [BL-1:0] s_cmd_cols_1;
  logic [BB-1:0] s_cmd_blocks_1;
  logic          pixels_valid, pixels_ready, weights_valid, weights_ready;
  logic          m_tready, m_tvalid, m_tlast, m_is_config;
  logic          m_is_top_block, m_is_bottom_block, m_is_cols_1_k2, m_is_cin_last;
  logic          busy, done;

  always #5 aclk = ~aclk;

  axis_input_scheduler dut (
    .aclk              (aclk),
    .areset            (areset),
    .s_cmd_tready      (s_cmd_tready),
    .s_cmd_tvalid      (s_cmd_tvalid),
    .s_cmd_is_1x1      (s_cmd_is_1x1),
    .s_cmd_kw_1        (s_cmd_kw_1),
    .s_cmd_cin_1       (s_cmd_cin_1),
    .s_cmd_cols_1      (s_cmd_cols_1),
    .s_cmd_blocks_1    (s_cmd_blocks_1),
    .pixels_valid      (pixels_valid),
    .pixels_ready      (pixels_ready),
    .weights_valid     (weights_valid),
    .weights_ready     (weights_ready),
    .m_tready          (m_tready),
    .m_tvalid          (m_tvalid),
    .m_tlast           (m_tlast),
    .m_is_config       (m_is_config),
    .m_is_top_block    (m_is_top_block),
    .m_is_bottom_block (m_is_bottom_block),
    .m_is_cols_1_k2    (m_is_cols_1_k2),
    .m_is_cin_last     (m_is_cin_last),
    .busy              (busy),
    .done              (done)
  );

  typedef struct { bit cfg; bit top; bit bot; bit k2; bit cinl; bit last; } beat_t;
  typedef struct { bit is1; int kw1; int cin1; int cols1; int blk1;
                   int ncfg; int ndata; int nk2; } vec_t;

  beat_t exp_q[$];
  int    n_tests = 0, n_fail = 0;
  int    cyc = 0, acc_cyc = -1, done_cyc = -1;
  int    cfg_seen = 0, data_seen = 0, k2_seen = 0;
  bit    pending_done = 0, accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the complete expected beat sequence of one layer.
  task automatic build(input bit is1, input int kw1, input int cin1, input int cols1,
                       input int blk1);
    beat_t b;
    int    thr;
    thr = cols1 - kw1 / 2;
    if (thr < 0) thr = 0;
    for (int i = 0; i < int'(is1 ? BEATS_CONFIG_1X1_1 + 1 : BEATS_CONFIG_3X3_1 + 1); i++) begin
      b = '{cfg: 1'b1, top: 1'b0, bot: 1'b0, k2: 1'b0, cinl: 1'b0, last: 1'b0};
      exp_q.push_back(b);
    end
    for (int bk = 0; bk <= blk1; bk++)
      for (int c = 0; c <= cols1; c++)
        for (int ci = 0; ci <= cin1; ci++) begin
          b.cfg  = 1'b0;
          b.top  = (bk == 0);
          b.bot  = (bk == blk1);
          b.k2   = (c >= thr);
          b.cinl = (ci == cin1);
          b.last = (bk == blk1) && (c == cols1) && (ci == cin1);
          exp_q.push_back(b);
        end
  endtask

  task automatic step();
    logic [5:0] flg;
    beat_t      e;
    bit         act_busy;
    @(negedge aclk);
    flg = {m_is_config, m_is_top_block, m_is_bottom_block, m_is_cols_1_k2,
           m_is_cin_last, m_tlast};
    if (areset) begin
      chk("reset_outputs", {19'd0, s_cmd_tready, m_tvalid, pixels_ready, weights_ready,
          flg, busy, done}, 32'd0);
      exp_q.delete();
      pending_done = 0;
    end else begin
      act_busy = (exp_q.size() > 0) || pending_done;
      chk("busy", busy, act_busy);
      chk("cmd_tready", s_cmd_tready, !act_busy);
      chk("done", done, pending_done);
      if (pending_done) begin
        done_cyc     = cyc;
        pending_done = 0;
      end
      if (exp_q.size() == 0) begin
        chk("idle_quiet", {m_tvalid, pixels_ready, weights_ready, flg}, 9'd0);
      end else begin
        e = exp_q[0];
        if (e.cfg) begin
          chk("cfg_tvalid", m_tvalid, weights_valid);
          chk("cfg_wready", weights_ready, m_tready);
          chk("cfg_pready", pixels_ready, 1'b0);
          chk("cfg_flags", flg, 6'b100000);
        end else begin
          chk("data_tvalid", m_tvalid, pixels_valid && weights_valid);
          chk("data_pready", pixels_ready, m_tready && weights_valid);
          chk("data_wready", weights_ready, m_tready && pixels_valid);
          chk("data_flags", flg, m_tvalid ? {1'b0, e.top, e.bot, e.k2, e.cinl, e.last}
                                          : 6'b000000);
        end
        if (m_tvalid && m_tready) begin
          void'(exp_q.pop_front());
          if (e.cfg) cfg_seen++;
          else begin
            data_seen++;
            if (e.k2) k2_seen++;
          end
          if (e.last) pending_done = 1;
        end
      end
      if (s_cmd_tready && s_cmd_tvalid) begin
        build(s_cmd_is_1x1, int'(s_cmd_kw_1), int'(s_cmd_cin_1), int'(s_cmd_cols_1),
              int'(s_cmd_blocks_1));
        acc_cyc  = cyc;
        accepted = 1;
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int pct);
    pixels_valid  = ($urandom % 100) < pct;
    weights_valid = ($urandom % 100) < pct;
    m_tready      = ($urandom % 100) < pct;
  endtask

  task automatic set_cmd(input bit is1, input int kw1, input int cin1, input int cols1,
                         input int blk1);
    s_cmd_is_1x1   = is1;
    s_cmd_kw_1     = BK'(kw1);
    s_cmd_cin_1    = BC'(cin1);
    s_cmd_cols_1   = BL'(cols1);
    s_cmd_blocks_1 = BB'(blk1);
    s_cmd_tvalid   = 1'b1;
  endtask

  task automatic accept_cmd(input int pct);
    int n = 0;
    accepted = 0;
    while (!accepted && n < 20000) begin
      drive(pct);
      step();
      n++;
    end
    chk("cmd_accept_timeout", accepted, 1'b1);
    cfg_seen  = 0;
    data_seen = 0;
    k2_seen   = 0;
  endtask

  task automatic wait_idle(input int pct);
    int n = 0;
    while (((exp_q.size() > 0) || pending_done) && n < 20000) begin
      drive(pct);
      step();
      n++;
    end
    chk("layer_timeout", (exp_q.size() > 0) || pending_done, 1'b0);
  endtask

  vec_t tbl[6];

  initial begin
    int exp_total;
    bit is1;
    int kw1, cin1, cols1, blk1, n;

    tbl[0] = '{1'b1, 0, 1, 2, 0, 9, 6, 2};
    tbl[1] = '{1'b0, 2, 0, 4, 1, 21, 10, 4};
    tbl[2] = '{1'b0, 2, 2, 1, 2, 21, 18, 18};
    tbl[3] = '{1'b1, 0, 0, 0, 0, 9, 1, 1};
    tbl[4] = '{1'b0, 1, 1, 0, 0, 21, 2, 2};
    tbl[5] = '{1'b0, 2, 0, 0, 1, 21, 2, 2};

    areset = 1'b1;
    s_cmd_tvalid = 1'b0;
    set_cmd(1'b0, 0, 0, 0, 0);
    s_cmd_tvalid = 1'b0;
    pixels_valid = 1'b0;
    weights_valid = 1'b0;
    m_tready = 1'b0;
    step();
    step();
    areset = 1'b0;
    step();

    // Table: always-valid layers, totals per layer
    foreach (tbl[i]) begin
      set_cmd(tbl[i].is1, tbl[i].kw1, tbl[i].cin1, tbl[i].cols1, tbl[i].blk1);
      accept_cmd(100);
      s_cmd_tvalid = 1'b0;
      chk("busy_after_accept", busy, 1'b1);
      wait_idle(100);
      chk($sformatf("tbl%0d_cfg_beats", i), cfg_seen, tbl[i].ncfg);
      chk($sformatf("tbl%0d_data_beats", i), data_seen, tbl[i].ndata);
      chk($sformatf("tbl%0d_k2_beats", i), k2_seen, tbl[i].nk2);
    end

    // Randomized handshakes at 50%
    for (int t = 0; t < 20; t++) begin
      is1   = $urandom_range(0, 1);
      kw1   = is1 ? 0 : $urandom_range(0, 2);
      cin1  = $urandom_range(0, 3);
      cols1 = $urandom_range(0, 5);
      blk1  = $urandom_range(0, 2);
      set_cmd(is1, kw1, cin1, cols1, blk1);
      accept_cmd(50);
      s_cmd_tvalid = 1'b0;
      wait_idle(50);
      exp_total = (is1 ? 9 : 21) + (cin1 + 1) * (cols1 + 1) * (blk1 + 1);
      chk("rand_total_fires", cfg_seen + data_seen, exp_total);
    end

    // Reset while beat 3 of DATA is presented
    set_cmd(1'b1, 0, 1, 2, 0);
    accept_cmd(100);
    s_cmd_tvalid = 1'b0;
    n = 0;
    while (data_seen < 2 && n < 200) begin
      drive(100);
      step();
      n++;
    end
    chk("abort_reached_beat3", data_seen, 2);
    areset = 1'b1;
    step();
    areset = 1'b0;
    step();
    chk("abort_idle_tready", s_cmd_tready, 1'b1);
    chk("abort_no_done", done, 1'b0);
    set_cmd(1'b0, 2, 1, 1, 1);
    accept_cmd(100);
    s_cmd_tvalid = 1'b0;
    wait_idle(100);
    chk("post_abort_cfg", cfg_seen, 21);
    chk("post_abort_data", data_seen, 8);

    // Second command held valid across a running layer
    set_cmd(1'b1, 0, 0, 1, 0);
    accept_cmd(100);
    set_cmd(1'b0, 1, 1, 0, 1);
    accept_cmd(100);
    chk("held_cmd_after_done", acc_cyc, done_cyc + 1);
    s_cmd_tvalid = 1'b0;
    wait_idle(100);
    chk("held_cmd_cfg", cfg_seen, 21);
    chk("held_cmd_data", data_seen, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
